seq_detector: RTL

- Parametrised serial sequence detector, successor to the fixed 3-state "11" detector FSM.
- Watches a qualified 1-bit input stream for a PAT_W-bit pattern. The pattern is reset-defined and runtime-reloadable.
- Supports overlapping or non-overlapping detection, and emits a registered one-cycle match pulse.
- Sits between a serial front end and control logic; exposes FSM state for waveform debug.

---
 rtl/seq_detector.sv | 108 ++++++++++
 1 files changed

// File: rtl/seq_detector.sv
// Serial pattern detector: shifts qualified bits into a window and pulses match when it equals a reloadable pattern.
// Optional saturating match counter is built only when SEQDET_MATCH_CNT_EN is defined.
module seq_detector #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    ARMED = 2'b10,
    HIT   = 2'b11
  } state_t;

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  state_t             state_reg;
  logic [PAT_W-1:0]   win_reg;
  logic [PAT_W-1:0]   win_next;
  logic [PAT_W-1:0]   pattern_reg;
  logic [FILL_W-1:0]  fill_reg;
  logic [FILL_W-1:0]  fill_inc;
  logic               match_reg;
  logic               accept;
  logic               hit;

  assign accept = in_valid & ~cfg_load;

  generate
    if (PAT_W == 1) begin : g_win_single
      assign win_next = in;
    end else begin : g_win_shift
      assign win_next = {win_reg[PAT_W-2:0], in};
    end
  endgenerate

  assign fill_inc = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + 1'b1;
  assign hit      = accept && (fill_inc == FILL_MAX) && (win_next == pattern_reg);

  // A HIT state behaves like ARMED or IDLE purely through fill, which is
  // flushed on a hit in non-overlapping mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      win_reg     <= '0;
      fill_reg    <= '0;
      pattern_reg <= PAT_RST;
      match_reg   <= 1'b0;
    end else if (cfg_load) begin
      pattern_reg <= cfg_pattern;
      fill_reg    <= '0;
      state_reg   <= IDLE;
      match_reg   <= 1'b0;
    end else if (accept) begin
      win_reg   <= win_next;
      match_reg <= hit;
      fill_reg  <= (hit && !OVERLAP) ? '0 : fill_inc;
      if (hit)
        state_reg <= HIT;
      else if (fill_inc == FILL_MAX)
        state_reg <= ARMED;
      else
        state_reg <= FILL;
    end else begin
      match_reg <= 1'b0;
      if (state_reg == HIT)
        state_reg <= OVERLAP ? ARMED : IDLE;
    end
  end

  assign match     = match_reg;
  assign state_dbg = state_reg;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  // Counts on the same edge that raises match; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (cnt_clr)
      cnt_reg <= '0;
    else if (hit && (cnt_reg != {CNT_W{1'b1}}))
      cnt_reg <= cnt_reg + 1'b1;
  end

  assign match_cnt = cnt_reg;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
